// File: rtl/mem_bus_bridge_pkg.sv
// Shared types and constants for the datapath-to-memory bridge.
// Imported by the interface, the wait counter and the bridge top.
package mem_bus_bridge_pkg;

  typedef enum logic [1:0] {
    BR_IDLE,
    BR_REQ,
    BR_DONE
  } bridgeState_t;

  localparam int unsigned AW_DEFAULT = 16;
  localparam int unsigned DW_DEFAULT = 16;
  localparam int unsigned TIMEOUT_DEFAULT = 15;
  localparam logic [15:0] ERR_DATA_DEFAULT = 16'hDEAD;

  function automatic logic strobe_on(
    input logic re_l,
    input logic we_l
  );
    return ~re_l | ~we_l;
  endfunction

endpackage

// File: rtl/mem_bus_bridge_if.sv
// Strobe-side and memory-side signals of the bridge.
// master = bridge, slave = datapath/memory environment.
interface mem_bus_bridge_if
  import mem_bus_bridge_pkg::*;
#(
  parameter int unsigned AW = AW_DEFAULT,
  parameter int unsigned DW = DW_DEFAULT
);

  logic [AW-1:0] memAddr;
  logic          re_L;
  logic          we_L;
  logic          stall;
  logic          bus_err;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  modport master (
    input  memAddr,
    input  re_L,
    input  we_L,
    input  mem_rdata,
    input  mem_ack,
    output stall,
    output bus_err,
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

  modport slave (
    output memAddr,
    output re_L,
    output we_L,
    output mem_rdata,
    output mem_ack,
    input  stall,
    input  bus_err,
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

endinterface

// File: rtl/mem_bus_bridge_wait_counter.sv
// Saturating wait counter; expired flags the last allowed cycle
// so the owner can abort on the LIMIT-th counted cycle.
module mem_bus_bridge_wait_counter
  import mem_bus_bridge_pkg::*;
#(
  parameter int unsigned LIMIT = TIMEOUT_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int unsigned W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != W'(LIMIT))) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q >= W'(LIMIT - 1));

endmodule

// File: rtl/mem_bus_bridge.sv
// Turns p18240 level memory strobes into a req/ack access,
// stalling control until done and returning read data for one cycle.
module mem_bus_bridge
  import mem_bus_bridge_pkg::*;
#(
  parameter int unsigned AW = AW_DEFAULT,
  parameter int unsigned DW = DW_DEFAULT,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
  parameter logic [DW-1:0] ERR_DATA = DW'(ERR_DATA_DEFAULT)
) (
  input  logic                clock,
  input  logic                reset,
  mem_bus_bridge_if.master    bus,
  inout  wire  [DW-1:0]       dataBus
);

  bridgeState_t  state_q;
  bridgeState_t  state_d;
  logic          mem_req_q;
  logic          mem_req_d;
  logic          mem_we_q;
  logic          mem_we_d;
  logic          bus_err_q;
  logic          bus_err_d;
  logic [AW-1:0] mem_addr_q;
  logic [AW-1:0] mem_addr_d;
  logic [DW-1:0] mem_wdata_q;
  logic [DW-1:0] mem_wdata_d;
  logic [DW-1:0] rd_buf_q;
  logic [DW-1:0] rd_buf_d;

  logic strobe;
  logic expired;
  logic drive_rd;

  assign strobe = strobe_on(bus.re_L, bus.we_L);

  mem_bus_bridge_wait_counter #(
    .LIMIT (TIMEOUT)
  ) u_wait (
    .clock   (clock),
    .reset   (reset),
    .clr     (state_q != BR_REQ),
    .inc     (state_q == BR_REQ),
    .expired (expired)
  );

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    bus_err_d   = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rd_buf_d    = rd_buf_q;
    unique case (state_q)
      BR_IDLE: begin
        if (strobe) begin
          state_d    = BR_REQ;
          mem_req_d  = 1'b1;
          mem_addr_d = bus.memAddr;
          mem_we_d   = ~bus.we_L;
          // both strobes low: do the write, flag the error
          bus_err_d  = ~bus.re_L & ~bus.we_L;
          if (~bus.we_L) begin
            mem_wdata_d = dataBus;
          end
        end
      end
      BR_REQ: begin
        if (bus.mem_ack) begin
          rd_buf_d  = bus.mem_rdata;
          mem_req_d = 1'b0;
          state_d   = BR_DONE;
        end else if (expired) begin
          rd_buf_d  = ERR_DATA;
          bus_err_d = 1'b1;
          mem_req_d = 1'b0;
          state_d   = BR_DONE;
        end
      end
      BR_DONE: begin
        state_d = BR_IDLE;
      end
      default: begin
        state_d   = BR_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= BR_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      bus_err_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_buf_q    <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      bus_err_q   <= bus_err_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rd_buf_q    <= rd_buf_d;
    end
  end

  // a read strobe dropped mid-access gets no data back
  assign drive_rd = (state_q == BR_DONE) & ~mem_we_q & ~bus.re_L;
  assign dataBus  = drive_rd ? rd_buf_q : {DW{1'bz}};

  assign bus.stall     = strobe & (state_q != BR_DONE);
  assign bus.bus_err   = bus_err_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Scoreboard bench for mem_bus_bridge: stimulus queues expectations,
// a negedge monitor compares whenever the bridge presents something.
module tb_mem_bus_bridge;

  localparam int TMO = 15;

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [15:0] wdata;
    int          len;
  } req_t;

  typedef struct {
    logic        drive;
    logic [15:0] data;
    logic        err;
    int          stall;
  } done_t;

  typedef struct {
    int          id;
    logic [31:0] exp;
  } lvl_t;

  logic clk = 1'b0;
  logic rst;
  logic tb_bus_en;
  logic [15:0] tb_bus_d;
  wire  [15:0] dataBus;

  mem_bus_bridge_if bus ();

  assign dataBus = tb_bus_en ? tb_bus_d : 16'hzzzz;

  mem_bus_bridge dut (
    .clock   (clk),
    .reset   (rst),
    .bus     (bus),
    .dataBus (dataBus)
  );

  always #5 clk = ~clk;

  req_t  req_q[$];
  done_t done_q[$];
  lvl_t  lvl_q[$];

  int n_pass = 0;
  int n_total = 0;

  function automatic void chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endfunction

  function automatic string lvl_name(input int id);
    case (id)
      0: return "mem_req";
      1: return "mem_we";
      2: return "bus_err";
      3: return "mem_addr";
      4: return "mem_wdata";
      5: return "stall";
      6: return "req_q_left";
      default: return "done_q_left";
    endcase
  endfunction

  // monitor state
  logic prev_req = 1'b0;
  logic prev_err = 1'b0;
  logic err_seen = 1'b0;
  int   stall_cnt = 0;
  int   req_len = 0;
  int   cur_len = 0;

  always @(negedge clk) begin : mon
    lvl_t        l;
    req_t        r;
    done_t       d;
    logic [31:0] act;
    logic        strobe;
    strobe = !bus.re_L || !bus.we_L;
    while (lvl_q.size() > 0) begin
      l = lvl_q.pop_front();
      case (l.id)
        0: act = 32'(bus.mem_req);
        1: act = 32'(bus.mem_we);
        2: act = 32'(bus.bus_err);
        3: act = 32'(bus.mem_addr);
        4: act = 32'(bus.mem_wdata);
        5: act = 32'(bus.stall);
        6: act = 32'(req_q.size());
        default: act = 32'(done_q.size());
      endcase
      chk(lvl_name(l.id), act, l.exp);
    end
    if (bus.mem_req && !prev_req) begin
      if (req_q.size() == 0) begin
        n_total++;
        $display("FAIL req_unexpected: got mem_req addr %0h, want none",
                 bus.mem_addr);
      end else begin
        r = req_q.pop_front();
        chk("req_addr", 32'(bus.mem_addr), 32'(r.addr));
        chk("req_we", 32'(bus.mem_we), 32'(r.we));
        if (r.we) chk("req_wdata", 32'(bus.mem_wdata), 32'(r.wdata));
        req_len = r.len;
      end
      cur_len = 1;
    end else if (bus.mem_req) begin
      cur_len++;
    end else if (prev_req) begin
      chk("req_len", 32'(cur_len), 32'(req_len));
    end
    if (rst) begin
      stall_cnt = 0;
      err_seen = 1'b0;
    end else begin
      if (bus.stall) stall_cnt++;
      if (bus.bus_err) begin
        chk("err_pulse", 32'(prev_err), 32'h0);
        err_seen = 1'b1;
      end
      if (strobe && !bus.stall) begin
        if (done_q.size() == 0) begin
          n_total++;
          $display("FAIL done_unexpected: got DONE cycle, want none");
        end else begin
          d = done_q.pop_front();
          chk("stall_len", 32'(stall_cnt), 32'(d.stall));
          chk("err_flag", 32'(err_seen), 32'(d.err));
          if (d.drive) begin
            chk("rd_data", 32'(dataBus), 32'(d.data));
          end else begin
            n_total++;
            if (dataBus !== 16'h5A5A) n_pass++;
            else $display("FAIL bus_quiet: got %0h, want undriven", dataBus);
          end
        end
        stall_cnt = 0;
        err_seen = 1'b0;
      end
    end
    prev_req = bus.mem_req;
    prev_err = bus.bus_err;
  end

  task automatic lvl(input int id, input logic [31:0] exp);
    lvl_t l;
    l.id = id;
    l.exp = exp;
    lvl_q.push_back(l);
  endtask

  task automatic idle(input int n);
    bus.re_L = 1'b1;
    bus.we_L = 1'b1;
    tb_bus_en = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // ack = k: ack in the k-th REQ cycle; ack = 0: never
  task automatic access(
    input bit          rd,
    input bit          wr,
    input logic [15:0] addr,
    input logic [15:0] wdat,
    input logic [15:0] rdat,
    input int          ack
  );
    req_t  r;
    done_t d;
    int    nreq;
    nreq = (ack == 0) ? TMO : ack;
    r.addr = addr;
    r.we = wr;
    r.wdata = wdat;
    r.len = nreq;
    req_q.push_back(r);
    d.drive = rd && !wr;
    d.data = (ack == 0) ? 16'hDEAD : rdat;
    d.err = (ack == 0) || (rd && wr);
    d.stall = nreq + 1;
    done_q.push_back(d);
    bus.memAddr = addr;
    bus.re_L = !rd;
    bus.we_L = !wr;
    tb_bus_en = wr;
    tb_bus_d = wdat;
    @(posedge clk); #1;
    tb_bus_en = 1'b0;
    for (int k = 1; k <= nreq; k++) begin
      if (k == ack) begin
        bus.mem_ack = 1'b1;
        bus.mem_rdata = rdat;
      end
      @(posedge clk); #1;
      bus.mem_ack = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic reset_mid();
    req_t r;
    r.addr = 16'h0200;
    r.we = 1'b0;
    r.wdata = 16'h0;
    r.len = 3;
    req_q.push_back(r);
    bus.memAddr = 16'h0200;
    bus.re_L = 1'b0;
    bus.we_L = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    lvl(0, 0);
    lvl(5, 1);
    @(negedge clk); #1;
    bus.re_L = 1'b1;
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 16'h7777;
    lvl(5, 0);
    lvl(3, 0);
    @(negedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    lvl(0, 0);
    lvl(2, 0);
    lvl(5, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.re_L = 1'b1;
    bus.we_L = 1'b1;
    bus.memAddr = 16'h0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = 16'h0;
    tb_bus_en = 1'b0;
    tb_bus_d = 16'h0;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) lvl(i, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);
    access(1, 0, 16'h0040, 16'h0000, 16'h1234, 2);
    idle(2);
    access(0, 1, 16'h0100, 16'hBEEF, 16'h5A5A, 1);
    idle(2);
    access(1, 0, 16'h0300, 16'h0000, 16'h9999, 0);
    idle(2);
    access(1, 0, 16'h0050, 16'h0000, 16'h4321, 1);
    access(0, 1, 16'h0060, 16'hCAFE, 16'h5A5A, 3);
    idle(2);
    access(1, 1, 16'h0070, 16'h1111, 16'h5A5A, 2);
    idle(2);
    reset_mid();
    idle(2);
    access(1, 0, 16'h00A0, 16'h0000, 16'h0F0F, 4);
    idle(3);
    lvl(6, 0);
    lvl(7, 0);
    @(negedge clk); #1;
    @(negedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
